display_frame_scheduler: RTL and testbench

Parametrised time-slice scheduler that owns the single VGA plot port and sequences one map-redraw slot followed by one slot per enabled character every frame. Generalises the fixed two-way map/character mux to N characters with fixed per-slot budgets, a per-character enable mask, and a frame-start snapshot of positions and mask. It adds start pulses that restart each sub-controller and a run/stop handshake. Sits between the map and character display controllers and the VGA adapter.

---
 rtl/display_frame_scheduler.sv | 257 +++++++++++++++++++++++++
 tb/tb_display_frame_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/display_frame_scheduler.sv
// -----------------------------------------------------------------------------
// display_frame_scheduler
//
// Time-slice owner of the single VGA plot port. Every frame it grants one
// map-redraw slot of MAP_CYCLES cycles, then one slot of CHAR_CYCLES cycles to
// each character enabled in the mask snapshotted at frame start, then a
// single DONE cycle. Positions and mask are frozen at frame start, so changes
// made mid-frame only take effect on the following frame.
//
// Optional feature macro: DISPLAY_OUT_REG_EN
//   defined   -> vga_plot/x/y/color are registered (one cycle of latency)
//   undefined -> vga_plot/x/y/color are a zero-latency combinational mux
//
// Ports
//   clock_50                          system clock, rising edge
//   resetn                            asynchronous active-low reset
//   run                               keep producing frames while high
//   char_en[NUM_CHAR]                 per-character enable mask
//   char_pos_x/char_pos_y             packed positions, index i at [i*XY_W +: XY_W]
//   map_plot/x/y/color                map controller pixel stream
//   cdc_plot/x/y/color                character controller pixel stream
//   map_start                         pulse on first cycle of the map slot
//   char_start                        pulse on first cycle of each character slot
//   char_sel, char_x, char_y          granted character and its frozen position
//   vga_plot/x/y/color                selected pixel stream
//   busy                              high during MAP or CHAR
//   frame_done                        pulse during the DONE cycle
// -----------------------------------------------------------------------------
module display_frame_scheduler #(
  parameter int NUM_CHAR    = 5,
  parameter int MAP_CYCLES  = 11025,
  parameter int CHAR_CYCLES = 101,
  parameter int XY_W        = 8,
  parameter int COLOR_W     = 3
) (
  input  logic                     clock_50,
  input  logic                     resetn,
  input  logic                     run,
  input  logic [NUM_CHAR-1:0]      char_en,
  input  logic [NUM_CHAR*XY_W-1:0] char_pos_x,
  input  logic [NUM_CHAR*XY_W-1:0] char_pos_y,
  input  logic                     map_plot,
  input  logic [XY_W-1:0]          map_x,
  input  logic [XY_W-1:0]          map_y,
  input  logic [COLOR_W-1:0]       map_color,
  input  logic                     cdc_plot,
  input  logic [XY_W-1:0]          cdc_x,
  input  logic [XY_W-1:0]          cdc_y,
  input  logic [COLOR_W-1:0]       cdc_color,
  output logic                     map_start,
  output logic                     char_start,
  output logic [2:0]               char_sel,
  output logic [XY_W-1:0]          char_x,
  output logic [XY_W-1:0]          char_y,
  output logic                     vga_plot,
  output logic [XY_W-1:0]          vga_x,
  output logic [XY_W-1:0]          vga_y,
  output logic [COLOR_W-1:0]       vga_color,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int MAX_CYC = (MAP_CYCLES > CHAR_CYCLES) ? MAP_CYCLES : CHAR_CYCLES;
  // A budget of 1 would give a zero-width counter; keep at least one bit.
  localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] MAP_LAST  = CNT_W'(MAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHAR_LAST = CNT_W'(CHAR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAP  = 2'd1,
    S_CHAR = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [2:0]                 idx_q, idx_d;
  logic [NUM_CHAR-1:0]        mask_q, mask_d;
  logic [NUM_CHAR*XY_W-1:0]   posx_q, posx_d;
  logic [NUM_CHAR*XY_W-1:0]   posy_q, posy_d;

  logic                       next_found;
  logic [2:0]                 next_idx;
  logic                       in_map;
  logic                       in_char;
  logic [XY_W-1:0]            sel_x;
  logic [XY_W-1:0]            sel_y;

  logic                       vga_plot_d;
  logic [XY_W-1:0]            vga_x_d;
  logic [XY_W-1:0]            vga_y_d;
  logic [COLOR_W-1:0]         vga_color_d;

  // Lowest enabled index above the current one; in MAP every index qualifies,
  // which yields the first character slot of the frame. The loop runs
  // downward so the last hit is the lowest qualifying index.
  always_comb begin
    next_found = 1'b0;
    next_idx   = 3'd0;
    for (int i = NUM_CHAR - 1; i >= 0; i--) begin
      if (mask_q[i] && ((state_q == S_MAP) || (3'(i) > idx_q))) begin
        next_found = 1'b1;
        next_idx   = 3'(i);
      end else begin
        next_found = next_found;
      end
    end
  end

  // Next-state, slot counter and frame-start snapshot logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (run) begin
          state_d = S_MAP;
          cnt_d   = '0;
          idx_d   = 3'd0;
          mask_d  = char_en;
          posx_d  = char_pos_x;
          posy_d  = char_pos_y;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_MAP: begin
        if (cnt_q == MAP_LAST) begin
          cnt_d = '0;
          if (next_found) begin
            state_d = S_CHAR;
            idx_d   = next_idx;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHAR: begin
        if (cnt_q == CHAR_LAST) begin
          cnt_d = '0;
          if (next_found) begin
            idx_d = next_idx;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Scheduler state register with asynchronous clear.
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      mask_q  <= '0;
      posx_q  <= '0;
      posy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
    end
  end

  // Frozen position of the granted character; constant-index loop avoids a
  // variable part-select that could reach past the last slot.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_CHAR; i++) begin
      if (idx_q == 3'(i)) begin
        sel_x = posx_q[i*XY_W +: XY_W];
        sel_y = posy_q[i*XY_W +: XY_W];
      end else begin
        sel_x = sel_x;
      end
    end
  end

  // Status and start pulses decoded from registered state only.
  always_comb begin
    in_map     = (state_q == S_MAP);
    in_char    = (state_q == S_CHAR);
    map_start  = in_map  && (cnt_q == '0);
    char_start = in_char && (cnt_q == '0);
    char_sel   = in_char ? idx_q : 3'd0;
    char_x     = in_char ? sel_x : '0;
    char_y     = in_char ? sel_y : '0;
    busy       = in_map || in_char;
    frame_done = (state_q == S_DONE);
  end

  // Plot-port mux: the owner of the current slot drives VGA, otherwise silence.
  always_comb begin
    if (in_map) begin
      vga_plot_d  = map_plot;
      vga_x_d     = map_x;
      vga_y_d     = map_y;
      vga_color_d = map_color;
    end else if (in_char) begin
      vga_plot_d  = cdc_plot;
      vga_x_d     = cdc_x;
      vga_y_d     = cdc_y;
      vga_color_d = cdc_color;
    end else begin
      vga_plot_d  = 1'b0;
      vga_x_d     = '0;
      vga_y_d     = '0;
      vga_color_d = '0;
    end
  end

`ifdef DISPLAY_OUT_REG_EN
  // Registered VGA port: everything lands one cycle later, slot edges included.
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      vga_plot  <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
    end else begin
      vga_plot  <= vga_plot_d;
      vga_x     <= vga_x_d;
      vga_y     <= vga_y_d;
      vga_color <= vga_color_d;
    end
  end
`else
  // Zero-latency VGA port.
  always_comb begin
    vga_plot  = vga_plot_d;
    vga_x     = vga_x_d;
    vga_y     = vga_y_d;
    vga_color = vga_color_d;
  end
`endif

endmodule

// File: tb/tb_display_frame_scheduler.sv
module tb_display_frame_scheduler;

  localparam int NC = 3;
  localparam int MC = 4;
  localparam int CC = 3;

  logic           clk = 1'b0;
  logic           resetn;
  logic           run;
  logic [NC-1:0]  char_en;
  logic [NC*8-1:0] char_pos_x;
  logic [NC*8-1:0] char_pos_y;
  logic           map_plot, cdc_plot;
  logic [7:0]     map_x, map_y, cdc_x, cdc_y;
  logic [2:0]     map_color, cdc_color;
  logic           map_start, char_start;
  logic [2:0]     char_sel;
  logic [7:0]     char_x, char_y;
  logic           vga_plot;
  logic [7:0]     vga_x, vga_y;
  logic [2:0]     vga_color;
  logic           busy, frame_done;

  display_frame_scheduler #(
    .NUM_CHAR(NC), .MAP_CYCLES(MC), .CHAR_CYCLES(CC), .XY_W(8), .COLOR_W(3)
  ) dut (
    .clock_50(clk), .resetn(resetn), .run(run), .char_en(char_en),
    .char_pos_x(char_pos_x), .char_pos_y(char_pos_y),
    .map_plot(map_plot), .map_x(map_x), .map_y(map_y), .map_color(map_color),
    .cdc_plot(cdc_plot), .cdc_x(cdc_x), .cdc_y(cdc_y), .cdc_color(cdc_color),
    .map_start(map_start), .char_start(char_start), .char_sel(char_sel),
    .char_x(char_x), .char_y(char_y),
    .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 map_start, 1 char_start, 2 frame_done, 3 overlapping pulses
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
    logic [2:0]  sel;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        busy;
    logic        vp;
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic [2:0]  vc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_act, mon_exp;
  int  errors = 0;
  int  checks = 0;

  function automatic ev_t mk(input logic [1:0] kind, input int c, input logic [2:0] sel,
                             input logic [7:0] x, input logic [7:0] y);
    ev_t e;
    e.kind = kind; e.cyc = c; e.sel = sel; e.x = x; e.y = y;
    if (kind == 2'd0) begin
      e.busy = 1'b1; e.vp = 1'b1; e.vx = 8'h11; e.vy = 8'h22; e.vc = 3'd5;
    end else if (kind == 2'd1) begin
      e.busy = 1'b1; e.vp = 1'b1; e.vx = 8'h33; e.vy = 8'h44; e.vc = 3'd6;
    end else begin
      e.busy = 1'b0; e.vp = 1'b0; e.vx = 8'h00; e.vy = 8'h00; e.vc = 3'd0;
    end
    return e;
  endfunction

  // Hand-built frame model: MAP, one slot per enabled index, then DONE.
  task automatic push_frame(input int start, input logic [2:0] m,
                            input logic [23:0] xs, input logic [23:0] ys,
                            output int done_c);
    int t;
    t = start;
    exp_q.push_back(mk(2'd0, t, 3'd0, 8'd0, 8'd0));
    t = t + MC;
    for (int i = 0; i < NC; i++) begin
      if (m[i]) begin
        exp_q.push_back(mk(2'd1, t, 3'(i), xs[i*8 +: 8], ys[i*8 +: 8]));
        t = t + CC;
      end
    end
    exp_q.push_back(mk(2'd2, t, 3'd0, 8'd0, 8'd0));
    done_c = t;
  endtask

  task automatic wait_until(input int c);
    while (cyc != c) @(negedge clk);
  endtask

  task automatic check_idle(input string nm);
    logic [42:0] all;
    all = {map_start, char_start, char_sel, char_x, char_y, vga_plot,
           vga_x, vga_y, vga_color, busy, frame_done};
    checks++;
    if (all !== 43'd0) begin
      errors++;
      $display("FAIL %s outputs act=%h exp=0", nm, all);
    end
  endtask

  // Monitor: every pulse on the DUT is matched against the next expected event.
  always @(negedge clk) begin
    if (map_start || char_start || frame_done) begin
      case ({map_start, char_start, frame_done})
        3'b100:  mon_act.kind = 2'd0;
        3'b010:  mon_act.kind = 2'd1;
        3'b001:  mon_act.kind = 2'd2;
        default: mon_act.kind = 2'd3;
      endcase
      mon_act.cyc  = cyc;
      mon_act.sel  = char_sel;
      mon_act.x    = char_x;
      mon_act.y    = char_y;
      mon_act.busy = busy;
      mon_act.vp   = vga_plot;
      mon_act.vx   = vga_x;
      mon_act.vy   = vga_y;
      mon_act.vc   = vga_color;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event act=%h exp=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL event(kind,cyc,sel,x,y,busy,vga) act=%h exp=%h", mon_act, mon_exp);
        end
      end
    end
  end

  int c0, c1, c2, d;

  initial begin
    resetn = 1'b0; run = 1'b0; char_en = '0; char_pos_x = '0; char_pos_y = '0;
    map_plot = 1'b1; map_x = 8'h11; map_y = 8'h22; map_color = 3'd5;
    cdc_plot = 1'b1; cdc_x = 8'h33; cdc_y = 8'h44; cdc_color = 3'd6;

    #3 check_idle("reset_state");
    @(negedge clk); @(negedge clk); resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_idle("idle_run_low");

    // Frame 1: full mask.
    @(negedge clk);
    char_en = 3'b111;
    char_pos_x = {8'd30, 8'd20, 8'd10};
    char_pos_y = {8'd102, 8'd101, 8'd100};
    run = 1'b1;
    c0 = cyc;
    push_frame(c0 + 1, 3'b111, {8'd30, 8'd20, 8'd10}, {8'd102, 8'd101, 8'd100}, d);

    // Mid-MAP change: frame 1 keeps old values, frame 2 sees mask 101.
    wait_until(c0 + 2);
    char_pos_x = {8'd30, 8'h99, 8'h77};
    char_en = 3'b101;
    push_frame(d + 1, 3'b101, {8'd30, 8'h99, 8'h77}, {8'd102, 8'd101, 8'd100}, d);

    // Frame 3: empty mask.
    wait_until(c0 + 20);
    char_en = 3'b000;
    push_frame(d + 1, 3'b000, 24'd0, 24'd0, d);

    // Frame 4: full mask again, run dropped during slot 1.
    wait_until(c0 + 27);
    char_en = 3'b111;
    push_frame(d + 1, 3'b111, {8'd30, 8'h99, 8'h77}, {8'd102, 8'd101, 8'd100}, d);
    wait_until(c0 + 39);
    run = 1'b0;
    wait_until(d + 1);
    #1 check_idle("idle_after_stop");
    wait_until(d + 3);
    #1 check_idle("idle_hold");

    // Asynchronous reset in the middle of character slot 1.
    @(negedge clk);
    c1 = cyc;
    run = 1'b1;
    exp_q.push_back(mk(2'd0, c1 + 1, 3'd0, 8'd0, 8'd0));
    exp_q.push_back(mk(2'd1, c1 + 5, 3'd0, 8'h77, 8'd100));
    exp_q.push_back(mk(2'd1, c1 + 8, 3'd1, 8'h99, 8'd101));
    wait_until(c1 + 9);
    #2 resetn = 1'b0;
    #1 check_idle("async_reset_midchar");
    @(negedge clk); @(negedge clk);
    c2 = cyc;
    resetn = 1'b1;
    push_frame(c2 + 1, 3'b111, {8'd30, 8'h99, 8'h77}, {8'd102, 8'd101, 8'd100}, d);
    wait_until(c2 + 3);
    run = 1'b0;
    wait_until(d + 1);
    #1 check_idle("idle_after_reset_frame");

    // Every expected event must have been seen.
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
